mem_lsu: RTL and testbench

Parametrised load/store unit that replaces the single-cycle MEM stage between EX and WB of the MIPS pipeline. It talks to data memory over a request/grant/response handshake with per-byte enables, so partial-word stores need no read-modify-write. It stalls the pipeline for the duration of each access and times out hung accesses. Non-memory instructions pass through with one cycle of latency.

---
 rtl/mem_lsu_if.sv | 22 ++
 rtl/mem_lsu.sv | 244 ++++++++++++++++++++++++
 tb/tb_mem_lsu.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_lsu_if.sv
// Data-memory request/grant/response channel between the load/store unit and data memory.
// Request fields are held stable by the master for as long as dm_req is high.
interface mem_lsu_if;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [3:0]  dm_be;
  logic [31:0] dm_wdata;
  logic        dm_gnt;
  logic        dm_rvalid;
  logic [31:0] dm_rdata;

  modport master (
    output dm_req, dm_we, dm_addr, dm_be, dm_wdata,
    input  dm_gnt, dm_rvalid, dm_rdata
  );

  modport slave (
    input  dm_req, dm_we, dm_addr, dm_be, dm_wdata,
    output dm_gnt, dm_rvalid, dm_rdata
  );
endinterface

// File: rtl/mem_lsu.sv
// MIPS MEM-stage load/store unit: handshake data-memory access with byte lanes, stall and timeout.
// Optional LSU_ALIGN_CHECK_EN faults misaligned halfword/word accesses instead of issuing them.
module mem_lsu #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] Instr1_IN,
  input  logic [31:0] Instr1_PC_IN,
  output logic [31:0] Instr1_OUT,
  output logic [31:0] Instr1_PC_OUT,
  input  logic        valid_IN,
  input  logic [31:0] ALU_result1_IN,
  input  logic [31:0] MemWriteData1_IN,
  input  logic [4:0]  WriteRegister1_IN,
  input  logic        RegWrite1_IN,
  input  logic [5:0]  ALU_Control1_IN,
  input  logic        MemRead1_IN,
  input  logic        MemWrite1_IN,
  output logic        stall_OUT,
  output logic        valid_OUT,
  output logic        RegWrite1_OUT,
  output logic [4:0]  WriteRegister1_OUT,
  output logic [31:0] WriteData1_OUT,
  output logic [31:0] MEM_Data_Forward,
  output logic        fault_OUT,
  output logic [31:0] fault_addr_OUT,
  mem_lsu_if.master   bus
);
  localparam logic [5:0] OP_LB  = 6'b100001, OP_LBU = 6'b101010, OP_LH  = 6'b101011,
                         OP_LHU = 6'b101100, OP_LW  = 6'b111101, OP_LWL = 6'b101101,
                         OP_LWR = 6'b101110, OP_SB  = 6'b101111, OP_SH  = 6'b110000,
                         OP_SW  = 6'b110001, OP_SWL = 6'b110010, OP_SWR = 6'b110011;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;
  state_t state, state_nxt;

  logic [CNT_W-1:0] cnt;
  logic [5:0]  op_p1;
  logic [31:0] addr_p1, rt_p1;
  logic [4:0]  wreg_p1;
  logic        regw_p1, load_p1;
  logic        dm_we_r;
  logic [3:0]  dm_be_r;
  logic [31:0] dm_addr_r, dm_wdata_r;

  logic        mem_op, misalign, tmo, capture, cnt_clr, cnt_inc, stall;
  logic        fault_nxt, wb_vld, wb_regw;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data, fault_addr_nxt;
  logic [35:0] st_lanes;

  // Big-endian lane extraction; k is the byte offset, lane 0 is [31:24].
  function automatic logic [31:0] load_align(input logic [5:0] op, input logic [1:0] k,
                                             input logic [31:0] rdata, input logic [31:0] rt);
    logic [31:0] sh;
    logic [15:0] h;
    logic [7:0]  b;
    sh = rdata << {k, 3'b000};
    b  = sh[31:24];
    h  = k[1] ? rdata[15:0] : rdata[31:16];
    case (op)
      OP_LB:   load_align = {{24{b[7]}}, b};
      OP_LBU:  load_align = {24'h0, b};
      OP_LH:   load_align = {{16{h[15]}}, h};
      OP_LHU:  load_align = {16'h0, h};
      OP_LW:   load_align = rdata;
      OP_LWL:  load_align = sh | (rt & ~(32'hFFFF_FFFF << {k, 3'b000}));
      OP_LWR:  load_align = (rdata >> {~k, 3'b000}) | (rt & ~(32'hFFFF_FFFF >> {~k, 3'b000}));
      default: load_align = rdata;
    endcase
  endfunction

  // Returns {byte enables, write data} with rt bytes steered into their target lanes.
  function automatic logic [35:0] store_lanes(input logic [5:0] op, input logic [1:0] k,
                                              input logic [31:0] rt);
    logic [3:0]  be;
    logic [31:0] wd;
    case (op)
      OP_SB:   begin be = 4'b1000 >> k; wd = {rt[7:0], 24'h0} >> {k, 3'b000}; end
      OP_SH:   begin be = k[1] ? 4'b0011 : 4'b1100; wd = k[1] ? {16'h0, rt[15:0]} : {rt[15:0], 16'h0}; end
      OP_SW:   begin be = 4'b1111; wd = rt; end
      OP_SWL:  begin be = 4'b1111 >> k; wd = rt >> {k, 3'b000}; end
      OP_SWR:  begin be = 4'b1111 << ~k; wd = rt << {~k, 3'b000}; end
      default: begin be = 4'b1111; wd = 32'h0; end
    endcase
    return {be, wd};
  endfunction

`ifdef LSU_ALIGN_CHECK_EN
  always_comb begin
    case (ALU_Control1_IN)
      OP_LH, OP_LHU, OP_SH: misalign = ALU_result1_IN[0];
      OP_LW, OP_SW:         misalign = |ALU_result1_IN[1:0];
      default:              misalign = 1'b0;
    endcase
  end
`else
  assign misalign = 1'b0;
`endif

  assign mem_op   = valid_IN & (MemRead1_IN | MemWrite1_IN);
  assign tmo      = (cnt == CNT_W'(TIMEOUT - 1));
  assign st_lanes = store_lanes(ALU_Control1_IN, ALU_result1_IN[1:0], MemWriteData1_IN);

  always_comb begin
    state_nxt      = state;
    capture        = 1'b0;
    cnt_clr        = 1'b0;
    cnt_inc        = 1'b0;
    stall          = 1'b0;
    fault_nxt      = 1'b0;
    fault_addr_nxt = fault_addr_OUT;
    wb_vld         = 1'b0;
    wb_regw        = 1'b0;
    wb_reg         = 5'd0;
    wb_data        = 32'h0;
    case (state)
      S_IDLE: begin
        if (mem_op) begin
          capture = 1'b1;
          stall   = 1'b1;
          if (misalign) begin
            state_nxt      = S_DONE;
            fault_nxt      = 1'b1;
            fault_addr_nxt = ALU_result1_IN;
            wb_vld         = 1'b1;
            wb_reg         = WriteRegister1_IN;
            wb_data        = ALU_result1_IN;
          end else begin
            state_nxt = S_REQ;
            cnt_clr   = 1'b1;
          end
        end else if (valid_IN) begin
          wb_vld  = 1'b1;
          wb_regw = RegWrite1_IN;
          wb_reg  = WriteRegister1_IN;
          wb_data = ALU_result1_IN;
        end
      end
      S_REQ: begin
        stall   = 1'b1;
        cnt_inc = 1'b1;
        // A grant arriving in the timeout cycle still completes the access.
        if (bus.dm_gnt) begin
          if (load_p1) begin
            state_nxt = S_WAIT;
          end else begin
            state_nxt = S_DONE;
            wb_vld    = 1'b1;
            wb_reg    = wreg_p1;
            wb_data   = addr_p1;
          end
        end else if (tmo) begin
          state_nxt      = S_DONE;
          fault_nxt      = 1'b1;
          fault_addr_nxt = addr_p1;
          wb_vld         = 1'b1;
          wb_reg         = wreg_p1;
          wb_data        = addr_p1;
        end
      end
      S_WAIT: begin
        stall   = 1'b1;
        cnt_inc = 1'b1;
        if (bus.dm_rvalid) begin
          state_nxt = S_DONE;
          wb_vld    = 1'b1;
          wb_regw   = regw_p1;
          wb_reg    = wreg_p1;
          wb_data   = load_align(op_p1, addr_p1[1:0], bus.dm_rdata, rt_p1);
        end else if (tmo) begin
          state_nxt      = S_DONE;
          fault_nxt      = 1'b1;
          fault_addr_nxt = addr_p1;
          wb_vld         = 1'b1;
          wb_reg         = wreg_p1;
          wb_data        = addr_p1;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign stall_OUT        = stall;
  assign MEM_Data_Forward = wb_data;
  assign bus.dm_req       = (state == S_REQ);
  assign bus.dm_we        = dm_we_r;
  assign bus.dm_addr      = dm_addr_r;
  assign bus.dm_be        = dm_be_r;
  assign bus.dm_wdata     = dm_wdata_r;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state              <= S_IDLE;
      cnt                <= '0;
      valid_OUT          <= 1'b0;
      RegWrite1_OUT      <= 1'b0;
      WriteRegister1_OUT <= 5'd0;
      WriteData1_OUT     <= 32'h0;
      fault_OUT          <= 1'b0;
      fault_addr_OUT     <= 32'h0;
      Instr1_OUT         <= 32'h0;
      Instr1_PC_OUT      <= 32'h0;
      dm_we_r            <= 1'b0;
      dm_be_r            <= 4'h0;
      dm_addr_r          <= 32'h0;
      dm_wdata_r         <= 32'h0;
    end else begin
      state              <= state_nxt;
      if (cnt_clr)      cnt <= '0;
      else if (cnt_inc) cnt <= cnt + 1'b1;
      valid_OUT          <= wb_vld;
      RegWrite1_OUT      <= wb_regw;
      WriteRegister1_OUT <= wb_reg;
      WriteData1_OUT     <= wb_data;
      fault_OUT          <= fault_nxt;
      fault_addr_OUT     <= fault_addr_nxt;
      if (state == S_IDLE) begin
        Instr1_OUT    <= Instr1_IN;
        Instr1_PC_OUT <= Instr1_PC_IN;
      end
      if (capture) begin
        dm_we_r                <= MemWrite1_IN;
        dm_addr_r              <= {ALU_result1_IN[31:2], 2'b00};
        {dm_be_r, dm_wdata_r}  <= st_lanes;
      end
    end
  end

  // Operand holding stage: loaded once per access, no reset needed.
  always_ff @(posedge CLK) begin
    if (capture) begin
      op_p1   <= ALU_Control1_IN;
      addr_p1 <= ALU_result1_IN;
      rt_p1   <= MemWriteData1_IN;
      wreg_p1 <= WriteRegister1_IN;
      regw_p1 <= RegWrite1_IN & ~MemWrite1_IN;
      load_p1 <= ~MemWrite1_IN;
    end
  end
endmodule

// File: tb/tb_mem_lsu.sv
// Directed testbench for mem_lsu: byte-lane loads/stores, timeout, reset mid-access, alignment option.
module tb_mem_lsu;
  localparam logic [5:0] OP_LB  = 6'b100001, OP_LBU = 6'b101010, OP_LH  = 6'b101011,
                         OP_LHU = 6'b101100, OP_LW  = 6'b111101, OP_LWL = 6'b101101,
                         OP_LWR = 6'b101110, OP_SB  = 6'b101111, OP_SH  = 6'b110000,
                         OP_SW  = 6'b110001, OP_SWL = 6'b110010, OP_SWR = 6'b110011,
                         OP_ADD = 6'b100000;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [31:0] Instr1_IN, Instr1_PC_IN, Instr1_OUT, Instr1_PC_OUT;
  logic        valid_IN, RegWrite1_IN, MemRead1_IN, MemWrite1_IN;
  logic [31:0] ALU_result1_IN, MemWriteData1_IN;
  logic [4:0]  WriteRegister1_IN, WriteRegister1_OUT;
  logic [5:0]  ALU_Control1_IN;
  logic        stall_OUT, valid_OUT, RegWrite1_OUT, fault_OUT;
  logic [31:0] WriteData1_OUT, MEM_Data_Forward, fault_addr_OUT;

  always #5 CLK = ~CLK;

  mem_lsu_if bus();

  // Memory model: grants combinationally when enabled, returns read data the cycle after a read grant.
  logic        gnt_en, rv_en, rv_force, pend;
  logic [31:0] mem_rdata;
  assign bus.dm_gnt    = bus.dm_req & gnt_en;
  assign bus.dm_rvalid = (pend & rv_en) | rv_force;
  assign bus.dm_rdata  = mem_rdata;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)                                      pend <= 1'b0;
    else if (bus.dm_req && bus.dm_gnt && !bus.dm_we) pend <= 1'b1;
    else if (bus.dm_rvalid)                         pend <= 1'b0;
  end

  mem_lsu #(.TIMEOUT(16), .CNT_W(5)) dut (
    .CLK(CLK), .RESET(RESET),
    .Instr1_IN(Instr1_IN), .Instr1_PC_IN(Instr1_PC_IN),
    .Instr1_OUT(Instr1_OUT), .Instr1_PC_OUT(Instr1_PC_OUT),
    .valid_IN(valid_IN), .ALU_result1_IN(ALU_result1_IN), .MemWriteData1_IN(MemWriteData1_IN),
    .WriteRegister1_IN(WriteRegister1_IN), .RegWrite1_IN(RegWrite1_IN),
    .ALU_Control1_IN(ALU_Control1_IN), .MemRead1_IN(MemRead1_IN), .MemWrite1_IN(MemWrite1_IN),
    .stall_OUT(stall_OUT), .valid_OUT(valid_OUT), .RegWrite1_OUT(RegWrite1_OUT),
    .WriteRegister1_OUT(WriteRegister1_OUT), .WriteData1_OUT(WriteData1_OUT),
    .MEM_Data_Forward(MEM_Data_Forward), .fault_OUT(fault_OUT), .fault_addr_OUT(fault_addr_OUT),
    .bus(bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  int          stalls;
  logic        saw_req, req_we;
  logic [3:0]  req_be;
  logic [31:0] req_addr, req_wdata, fwd;

  // Presents one op and holds it until stall drops; returns in the cycle after stall falls.
  task automatic run_op(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] rt,
                        input logic rd, input logic wr, input logic regw, input logic [4:0] wreg);
    valid_IN          = 1'b1;
    ALU_Control1_IN   = op;
    ALU_result1_IN    = addr;
    MemWriteData1_IN  = rt;
    MemRead1_IN       = rd;
    MemWrite1_IN      = wr;
    RegWrite1_IN      = regw;
    WriteRegister1_IN = wreg;
    stalls  = 0;
    saw_req = 1'b0;
    fwd     = 32'h0;
    #2;
    while (stall_OUT && stalls < 64) begin
      fwd = MEM_Data_Forward;
      if (bus.dm_req) begin
        saw_req   = 1'b1;
        req_we    = bus.dm_we;
        req_be    = bus.dm_be;
        req_addr  = bus.dm_addr;
        req_wdata = bus.dm_wdata;
      end
      stalls++;
      @(posedge CLK); #2;
    end
  endtask

  task automatic bubble();
    valid_IN     = 1'b0;
    MemRead1_IN  = 1'b0;
    MemWrite1_IN = 1'b0;
    RegWrite1_IN = 1'b0;
    @(posedge CLK); #2;
  endtask

  typedef struct packed {
    logic [5:0]  op;
    logic [31:0] addr, rt, rdata, res;
  } ld_vec_t;

  typedef struct packed {
    logic [5:0]  op;
    logic [31:0] addr, rt;
    logic [3:0]  be;
    logic [31:0] wd;
  } st_vec_t;

  ld_vec_t ld_tab [8];
  st_vec_t st_tab [7];

  initial begin
    Instr1_IN = 32'h0; Instr1_PC_IN = 32'h0; valid_IN = 1'b0; RegWrite1_IN = 1'b0;
    MemRead1_IN = 1'b0; MemWrite1_IN = 1'b0; ALU_result1_IN = 32'h0; MemWriteData1_IN = 32'h0;
    WriteRegister1_IN = 5'd0; ALU_Control1_IN = 6'd0;
    gnt_en = 1'b1; rv_en = 1'b1; rv_force = 1'b0; mem_rdata = 32'h0;

    ld_tab[0] = '{OP_LB,  32'h1001, 32'h0,       32'h12F4_5678, 32'hFFFF_FFF4};
    ld_tab[1] = '{OP_LBU, 32'h1001, 32'h0,       32'h12F4_5678, 32'h0000_00F4};
    ld_tab[2] = '{OP_LH,  32'h1000, 32'h0,       32'h8001_5678, 32'hFFFF_8001};
    ld_tab[3] = '{OP_LHU, 32'h1002, 32'h0,       32'h12F4_5678, 32'h0000_5678};
    ld_tab[4] = '{OP_LW,  32'h1004, 32'h0,       32'h12F4_5678, 32'h12F4_5678};
    ld_tab[5] = '{OP_LWL, 32'h3001, 32'h9999_9999, 32'h1122_3344, 32'h2233_4499};
    ld_tab[6] = '{OP_LWR, 32'h3001, 32'h9999_9999, 32'h1122_3344, 32'h9999_1122};
    ld_tab[7] = '{OP_LWR, 32'h3000, 32'h9999_9999, 32'h1122_3344, 32'h9999_9911};

    st_tab[0] = '{OP_SWR, 32'h2002, 32'hAABB_CCDD, 4'b1110, 32'hBBCC_DD00};
    st_tab[1] = '{OP_SWR, 32'h2000, 32'hAABB_CCDD, 4'b1000, 32'hDD00_0000};
    st_tab[2] = '{OP_SWL, 32'h5001, 32'hAABB_CCDD, 4'b0111, 32'h00AA_BBCC};
    st_tab[3] = '{OP_SB,  32'h5003, 32'h1234_56AB, 4'b0001, 32'h0000_00AB};
    st_tab[4] = '{OP_SB,  32'h5000, 32'h1234_56AB, 4'b1000, 32'hAB00_0000};
    st_tab[5] = '{OP_SH,  32'h5002, 32'hDEAD_1234, 4'b0011, 32'h0000_1234};
    st_tab[6] = '{OP_SW,  32'h5000, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D};

    repeat (2) @(posedge CLK); #2;
    chk("rst_valid", 32'(valid_OUT), 32'd0);
    chk("rst_wdata", WriteData1_OUT, 32'h0);
    chk("rst_req",   32'(bus.dm_req), 32'd0);
    chk("rst_stall", 32'(stall_OUT), 32'd0);
    chk("rst_fault", 32'(fault_OUT), 32'd0);
    RESET = 1'b0;
    @(posedge CLK); #2;

    // Non-memory op: one cycle latency, no stall.
    valid_IN = 1'b1; ALU_Control1_IN = OP_ADD; ALU_result1_IN = 32'h0000_1234;
    RegWrite1_IN = 1'b1; WriteRegister1_IN = 5'd7; Instr1_IN = 32'h2402_0005;
    #2;
    chk("alu_stall", 32'(stall_OUT), 32'd0);
    chk("alu_fwd",   MEM_Data_Forward, 32'h0000_1234);
    @(posedge CLK); #2;
    chk("alu_valid", 32'(valid_OUT), 32'd1);
    chk("alu_data",  WriteData1_OUT, 32'h0000_1234);
    chk("alu_reg",   32'(WriteRegister1_OUT), 32'd7);
    chk("alu_regw",  32'(RegWrite1_OUT), 32'd1);
    chk("alu_instr", Instr1_OUT, 32'h2402_0005);
    bubble();
    chk("alu_bubble", 32'(valid_OUT), 32'd0);

    for (int i = 0; i < 8; i++) begin
      mem_rdata = ld_tab[i].rdata;
      run_op(ld_tab[i].op, ld_tab[i].addr, ld_tab[i].rt, 1'b1, 1'b0, 1'b1, 5'd3);
      chk($sformatf("ld%0d_stall", i), 32'(stalls), 32'd3);
      chk($sformatf("ld%0d_addr", i), req_addr, {ld_tab[i].addr[31:2], 2'b00});
      chk($sformatf("ld%0d_we", i), 32'(req_we), 32'd0);
      chk($sformatf("ld%0d_fwd", i), fwd, ld_tab[i].res);
      chk($sformatf("ld%0d_data", i), WriteData1_OUT, ld_tab[i].res);
      chk($sformatf("ld%0d_regw", i), 32'(RegWrite1_OUT), 32'd1);
      chk($sformatf("ld%0d_valid", i), 32'(valid_OUT), 32'd1);
      bubble();
    end

    for (int i = 0; i < 7; i++) begin
      run_op(st_tab[i].op, st_tab[i].addr, st_tab[i].rt, 1'b0, 1'b1, 1'b1, 5'd4);
      chk($sformatf("st%0d_stall", i), 32'(stalls), 32'd2);
      chk($sformatf("st%0d_addr", i), req_addr, {st_tab[i].addr[31:2], 2'b00});
      chk($sformatf("st%0d_we", i), 32'(req_we), 32'd1);
      chk($sformatf("st%0d_be", i), 32'(req_be), 32'(st_tab[i].be));
      chk($sformatf("st%0d_wd", i), req_wdata, st_tab[i].wd);
      chk($sformatf("st%0d_regw", i), 32'(RegWrite1_OUT), 32'd0);
      chk($sformatf("st%0d_valid", i), 32'(valid_OUT), 32'd1);
      bubble();
    end

    // Grant withheld: abort after 16 cycles in REQ.
    gnt_en = 1'b0;
    run_op(OP_LW, 32'h6000, 32'h0, 1'b1, 1'b0, 1'b1, 5'd9);
    chk("tmo_stall", 32'(stalls), 32'd17);
    chk("tmo_fault", 32'(fault_OUT), 32'd1);
    chk("tmo_faddr", fault_addr_OUT, 32'h6000);
    chk("tmo_regw",  32'(RegWrite1_OUT), 32'd0);
    bubble();
    chk("tmo_pulse", 32'(fault_OUT), 32'd0);
    gnt_en = 1'b1;
    run_op(OP_SW, 32'h6004, 32'h0102_0304, 1'b0, 1'b1, 1'b0, 5'd0);
    chk("tmo_next_stall", 32'(stalls), 32'd2);
    chk("tmo_next_wd",    req_wdata, 32'h0102_0304);
    bubble();

    mem_rdata = 32'h0BAD_F00D;
    run_op(OP_LW, 32'h4002, 32'h0, 1'b1, 1'b0, 1'b1, 5'd5);
`ifdef LSU_ALIGN_CHECK_EN
    chk("al_stall", 32'(stalls), 32'd1);
    chk("al_noreq", 32'(saw_req), 32'd0);
    chk("al_fault", 32'(fault_OUT), 32'd1);
    chk("al_faddr", fault_addr_OUT, 32'h4002);
    chk("al_regw",  32'(RegWrite1_OUT), 32'd0);
`else
    chk("al_stall", 32'(stalls), 32'd3);
    chk("al_addr",  req_addr, 32'h4000);
    chk("al_data",  WriteData1_OUT, 32'h0BAD_F00D);
    chk("al_fault", 32'(fault_OUT), 32'd0);
`endif
    bubble();

    // Reset while waiting for read data.
    rv_en = 1'b0;
    valid_IN = 1'b1; ALU_Control1_IN = OP_LW; ALU_result1_IN = 32'h7000;
    MemRead1_IN = 1'b1; MemWrite1_IN = 1'b0; RegWrite1_IN = 1'b1; WriteRegister1_IN = 5'd6;
    @(posedge CLK); #2;
    @(posedge CLK); #2;
    chk("rw_in_wait", 32'(stall_OUT), 32'd1);
    RESET = 1'b1;
    valid_IN = 1'b0; MemRead1_IN = 1'b0; RegWrite1_IN = 1'b0;
    #1;
    chk("rw_req",   32'(bus.dm_req), 32'd0);
    chk("rw_stall", 32'(stall_OUT), 32'd0);
    chk("rw_daddr", bus.dm_addr, 32'h0);
    chk("rw_valid", 32'(valid_OUT), 32'd0);
    @(posedge CLK); #2;
    RESET = 1'b0;
    rv_en = 1'b1;
    rv_force = 1'b1;
    @(posedge CLK); #2;
    rv_force = 1'b0;
    chk("rw_stray_valid", 32'(valid_OUT), 32'd0);
    chk("rw_stray_stall", 32'(stall_OUT), 32'd0);
    mem_rdata = 32'h12F4_5678;
    run_op(OP_LB, 32'h1001, 32'h0, 1'b1, 1'b0, 1'b1, 5'd2);
    chk("rw_next_stall", 32'(stalls), 32'd3);
    chk("rw_next_data",  WriteData1_OUT, 32'hFFFF_FFF4);
    bubble();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule
